// File: rtl/link_sched_pkg.sv
// Shared types and helpers for the link token scheduler.
package link_sched_pkg;

  // Field widths of the downstream transaction id: {node, seq, pad, idx}.
  localparam int unsigned NODE_W = 8;
  localparam int unsigned SEQ_W  = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned PAD_W  = 32 - NODE_W - SEQ_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } sched_state_e;

  // One beat on the split link.
  typedef struct packed {
    logic        wen;
    logic [31:0] token;
    logic [31:0] clk_cnt;
    logic [31:0] id;
  } link_beat_t;

  function automatic logic [31:0] make_id(input logic [NODE_W-1:0] node,
                                          input logic [SEQ_W-1:0]  seq,
                                          input logic [IDX_W-1:0]  idx);
    return {node, seq, {PAD_W{1'b0}}, idx};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping around.
module rr_arbiter
  import link_sched_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             enable,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             sum;

  // Rotate requests so bit 0 is the pointer position, then take the first set bit.
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    sum = 0;
    idx = '0;
    any = 1'b0;
    if (enable) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!any && rot[i]) begin
          any = 1'b1;
          sum = int'(ptr) + i;
          if (sum >= int'(N)) sum = sum - int'(N);
          idx = IDX_W'(sum);
        end
      end
    end
    gnt = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/link_token_sched.sv
// Round-robin scheduler sharing one split-link channel between N_REQ requesters.
// One transaction outstanding at a time: grant -> SEND beat -> WAIT for ack or timeout.
module link_token_sched
  import link_sched_pkg::*;
#(
  parameter int unsigned        N_REQ   = 4,
  parameter int unsigned        TIMEOUT = 16,
  parameter logic [NODE_W-1:0]  LINK_ID = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [32*N_REQ-1:0]  i_token,
  output logic [N_REQ-1:0]     o_gnt,
  output logic [N_REQ-1:0]     o_done,
  output logic [31:0]          o_rsp_token,
  output logic [31:0]          o_lat,
  output logic                 o_timeout,
  output logic [7:0]           o_stray_cnt,
  output logic                 o_busy,
  output logic                 o_wen_down,
  output logic [31:0]          o_token_down,
  output logic [31:0]          o_clk_cnt_down,
  output logic [31:0]          o_id_down,
  input  logic                 i_wen_up,
  input  logic [31:0]          i_token_up,
  input  logic [31:0]          i_clk_cnt_up,
  input  logic [31:0]          i_id_up
);

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] ptr_q, idx_q, ptr_nxt;
  logic [IDX_W:0]   idx_inc;
  logic [SEQ_W-1:0] seq_q;
  logic [31:0]      cnt_q, wcnt_q, token_q, stamp_q, id_q, rsp_q, lat_q;
  logic [7:0]       stray_q;
  logic [N_REQ-1:0] done_q;
  logic             timeout_q;

  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;
  logic [31:0]      tok_sel;
  logic             ack_match, expire;
  link_beat_t       beat;

  // Remote stamp is reserved for future use.
  logic unused_clk_cnt_up;
  assign unused_clk_cnt_up = ^i_clk_cnt_up;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .req    (i_req),
    .ptr    (ptr_q),
    .enable (state_q == IDLE),
    .gnt    (arb_gnt),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  // Token mux for the winner, plus ack match / expiry decode and pointer advance.
  always_comb begin
    tok_sel = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (arb_gnt[k]) tok_sel = i_token[32*k +: 32];
    end
    ack_match = (state_q == WAIT) && i_wen_up && (i_id_up == id_q);
    expire    = (state_q == WAIT) && (wcnt_q == 32'(TIMEOUT - 1));
    idx_inc   = {1'b0, arb_idx} + (IDX_W+1)'(1);
    ptr_nxt   = (idx_inc == (IDX_W+1)'(N_REQ)) ? '0 : idx_inc[IDX_W-1:0];
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; a matching ack on the expiry edge still counts as done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_any) state_d = SEND;
      SEND:    state_d = WAIT;
      WAIT:    if (ack_match || expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: cycle counter, captured beat, sequence, wait counter, completion pulses.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      cnt_q     <= '0;
      ptr_q     <= '0;
      idx_q     <= '0;
      seq_q     <= '0;
      wcnt_q    <= '0;
      token_q   <= '0;
      stamp_q   <= '0;
      id_q      <= '0;
      rsp_q     <= '0;
      lat_q     <= '0;
      stray_q   <= '0;
      done_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_q + 32'd1;
      done_q    <= '0;
      timeout_q <= 1'b0;
      if (i_wen_up && !ack_match && (stray_q != 8'hFF)) stray_q <= stray_q + 8'd1;
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            idx_q   <= arb_idx;
            ptr_q   <= ptr_nxt;
            token_q <= tok_sel;
            stamp_q <= cnt_q;
            id_q    <= make_id(LINK_ID, seq_q, arb_idx);
          end
        end
        SEND: begin
          seq_q  <= seq_q + SEQ_W'(1);
          wcnt_q <= '0;
        end
        WAIT: begin
          wcnt_q <= wcnt_q + 32'd1;
          if (ack_match) begin
            done_q <= N_REQ'(1) << idx_q;
            rsp_q  <= i_token_up;
            lat_q  <= cnt_q - stamp_q;
          end else if (expire) begin
            timeout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: beat strobe and grant are decoded from SEND, the rest are registered.
  always_comb begin
    beat.wen     = (state_q == SEND);
    beat.token   = token_q;
    beat.clk_cnt = stamp_q;
    beat.id      = id_q;
    o_gnt          = beat.wen ? (N_REQ'(1) << idx_q) : '0;
    o_busy         = (state_q != IDLE);
    o_wen_down     = beat.wen;
    o_token_down   = beat.token;
    o_clk_cnt_down = beat.clk_cnt;
    o_id_down      = beat.id;
    o_done         = done_q;
    o_timeout      = timeout_q;
    o_rsp_token    = rsp_q;
    o_lat          = lat_q;
    o_stray_cnt    = stray_q;
  end

endmodule

// File: tb/tb_link_token_sched.sv
// Scoreboard bench for link_token_sched: expected beats/completions are queued when
// stimulus is driven and popped when the DUT shows the SEND beat or the done pulse.
module tb_link_token_sched;

  localparam logic [7:0] LINK_ID = 8'h5A;

  logic        clk = 1'b0;
  logic        i_rstn;
  logic [3:0]  i_req;
  logic [127:0] i_token;
  logic [31:0] tok [4];
  logic [3:0]  o_gnt, o_done;
  logic [31:0] o_rsp_token, o_lat, o_token_down, o_clk_cnt_down, o_id_down;
  logic        o_timeout, o_busy, o_wen_down;
  logic [7:0]  o_stray_cnt;
  logic        i_wen_up;
  logic [31:0] i_token_up, i_clk_cnt_up, i_id_up;

  assign i_token = {tok[3], tok[2], tok[1], tok[0]};

  always #5 clk = ~clk;

  link_token_sched #(
    .N_REQ   (4),
    .TIMEOUT (16),
    .LINK_ID (LINK_ID)
  ) dut (
    .i_clk          (clk),
    .i_rstn         (i_rstn),
    .i_req          (i_req),
    .i_token        (i_token),
    .o_gnt          (o_gnt),
    .o_done         (o_done),
    .o_rsp_token    (o_rsp_token),
    .o_lat          (o_lat),
    .o_timeout      (o_timeout),
    .o_stray_cnt    (o_stray_cnt),
    .o_busy         (o_busy),
    .o_wen_down     (o_wen_down),
    .o_token_down   (o_token_down),
    .o_clk_cnt_down (o_clk_cnt_down),
    .o_id_down      (o_id_down),
    .i_wen_up       (i_wen_up),
    .i_token_up     (i_token_up),
    .i_clk_cnt_up   (i_clk_cnt_up),
    .i_id_up        (i_id_up)
  );

  typedef struct {
    logic [3:0]  gnt;
    logic [31:0] token;
    logic [31:0] id;
  } beat_t;

  typedef struct {
    logic [3:0]  done;
    logic [31:0] rsp;
    logic [31:0] lat;
  } cpl_t;

  beat_t exp_beats[$];
  cpl_t  exp_cpl[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_ptr;
  logic [15:0] m_seq;
  int          m_stray;
  logic [31:0] mcnt;
  logic [31:0] send_mcnt;

  // Reference cycle counter, equal to the DUT counter just after each edge.
  always @(posedge clk) mcnt <= !i_rstn ? 32'd0 : mcnt + 32'd1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [3:0] req, input int ptr);
    int j;
    for (int i = 0; i < 4; i++) begin
      j = (ptr + i) % 4;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  task automatic do_reset();
    i_rstn = 1'b0;
    i_req = '0;
    i_wen_up = 1'b0;
    i_id_up = '0;
    i_token_up = '0;
    i_clk_cnt_up = '0;
    step();
    step();
    i_rstn = 1'b1;
    m_ptr = 0;
    m_seq = '0;
    m_stray = 0;
    exp_beats.delete();
    exp_cpl.delete();
  endtask

  // Raise requests, queue the expected beat and wait (bounded) for the SEND cycle.
  task automatic issue(input logic [3:0] req, output bit ok);
    int    k;
    beat_t b;
    k = rr_pick(req, m_ptr);
    b.gnt = 4'b0001 << k;
    b.token = tok[k];
    b.id = {LINK_ID, m_seq, 4'h0, 4'(k)};
    exp_beats.push_back(b);
    m_ptr = (k + 1) % 4;
    m_seq = m_seq + 16'd1;
    i_req = req;
    ok = 1'b0;
    for (int n = 0; n < 8; n++) begin
      step();
      if (o_wen_down === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    send_mcnt = mcnt;
  endtask

  task automatic test_reset();
    tok[0] = 32'h0; tok[1] = 32'h0; tok[2] = 32'h0; tok[3] = 32'h0;
    do_reset();
    n_checks++;
    if ({o_gnt, o_done, o_timeout, o_wen_down} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b required 0", {o_gnt, o_done, o_timeout, o_wen_down});
    end
    n_checks++;
    if ({o_token_down, o_clk_cnt_down, o_id_down, o_rsp_token, o_lat} !== 160'b0) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 0",
               {o_token_down, o_clk_cnt_down, o_id_down, o_rsp_token, o_lat});
    end
    n_checks++;
    if (o_busy !== 1'b0 || o_stray_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_busy_stray: got busy=%b stray=%0d required 0/0", o_busy, o_stray_cnt);
    end
  endtask

  task automatic test_single();
    bit    ok;
    beat_t b;
    cpl_t  c;
    do_reset();
    tok[0] = 32'hA5A5_0001;
    issue(4'b0001, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_send: no SEND beat seen"); end
    b = exp_beats.pop_front();
    n_checks++;
    if (o_gnt !== b.gnt || o_token_down !== b.token) begin
      n_fail++;
      $display("FAIL single_beat: got gnt=%b tok=%h required %b %h", o_gnt, o_token_down, b.gnt,
               b.token);
    end
    n_checks++;
    if (o_id_down !== b.id || o_clk_cnt_down !== send_mcnt - 32'd1) begin
      n_fail++;
      $display("FAIL single_id_stamp: got %h %h required %h %h", o_id_down, o_clk_cnt_down, b.id,
               send_mcnt - 32'd1);
    end
    i_req = '0;
    tok[0] = 32'hDEAD_BEEF;
    step();
    n_checks++;
    if (o_wen_down !== 1'b0 || o_gnt !== 4'b0 || o_busy !== 1'b1 || o_token_down !== b.token) begin
      n_fail++;
      $display("FAIL single_wait_hold: got wen=%b gnt=%b busy=%b tok=%h required 0 0 1 %h",
               o_wen_down, o_gnt, o_busy, o_token_down, b.token);
    end
    step();
    i_wen_up = 1'b1;
    i_id_up = b.id;
    i_token_up = 32'h0000_1234;
    c.done = 4'b0001;
    c.rsp = 32'h0000_1234;
    c.lat = mcnt - send_mcnt + 32'd1;
    exp_cpl.push_back(c);
    step();
    i_wen_up = 1'b0;
    c = exp_cpl.pop_front();
    n_checks++;
    if (o_done !== c.done || o_rsp_token !== c.rsp || o_lat !== c.lat) begin
      n_fail++;
      $display("FAIL single_done: got %b %h %0d required %b %h %0d", o_done, o_rsp_token, o_lat,
               c.done, c.rsp, c.lat);
    end
    n_checks++;
    if (o_lat !== 32'd3 || o_timeout !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_lat3: got lat=%0d to=%b busy=%b required 3 0 0", o_lat, o_timeout,
               o_busy);
    end
    step();
    n_checks++;
    if (o_done !== 4'b0) begin
      n_fail++;
      $display("FAIL single_done_pulse: got %b required 0000", o_done);
    end
  endtask

  task automatic test_fairness();
    bit          ok;
    beat_t       b;
    cpl_t        c;
    logic [31:0] last;
    do_reset();
    for (int k = 0; k < 4; k++) tok[k] = 32'h1000_0000 + k;
    last = '0;
    for (int g = 0; g < 5; g++) begin
      issue(4'b1111, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL fair_send%0d: no SEND beat seen", g); end
      b = exp_beats.pop_front();
      n_checks++;
      if (o_gnt !== b.gnt || o_id_down !== b.id || o_token_down !== b.token) begin
        n_fail++;
        $display("FAIL fair_beat%0d: got %b %h %h required %b %h %h", g, o_gnt, o_id_down,
                 o_token_down, b.gnt, b.id, b.token);
      end
      if (g > 0) begin
        n_checks++;
        if (send_mcnt - last !== 32'd3) begin
          n_fail++;
          $display("FAIL fair_spacing%0d: got %0d required 3", g, send_mcnt - last);
        end
      end
      last = send_mcnt;
      step();
      i_wen_up = 1'b1;
      i_id_up = b.id;
      i_token_up = 32'hC000_0000 + g;
      c.done = b.gnt;
      c.rsp = 32'hC000_0000 + g;
      c.lat = mcnt - send_mcnt + 32'd1;
      exp_cpl.push_back(c);
      step();
      i_wen_up = 1'b0;
      c = exp_cpl.pop_front();
      n_checks++;
      if (o_done !== c.done || o_rsp_token !== c.rsp || o_lat !== c.lat) begin
        n_fail++;
        $display("FAIL fair_done%0d: got %b %h %0d required %b %h %0d", g, o_done, o_rsp_token,
                 o_lat, c.done, c.rsp, c.lat);
      end
    end
    i_req = '0;
  endtask

  task automatic test_timeout();
    bit    ok;
    bit    early;
    beat_t b;
    do_reset();
    tok[0] = 32'h7000_0000;
    tok[1] = 32'h7000_0001;
    issue(4'b0001, ok);
    b = exp_beats.pop_front();
    n_checks++;
    if (!ok || o_gnt !== b.gnt) begin
      n_fail++;
      $display("FAIL to_send: got ok=%b gnt=%b required 1 %b", ok, o_gnt, b.gnt);
    end
    i_req = '0;
    early = 1'b0;
    for (int w = 0; w < 16; w++) begin
      step();
      if (o_timeout !== 1'b0 || o_done !== 4'b0 || o_busy !== 1'b1) early = 1'b1;
    end
    n_checks++;
    if (early) begin
      n_fail++;
      $display("FAIL to_wait16: got early exit from WAIT required 16 busy cycles");
    end
    step();
    n_checks++;
    if (o_timeout !== 1'b1 || o_done !== 4'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL to_pulse: got to=%b done=%b busy=%b required 1 0000 0", o_timeout, o_done,
               o_busy);
    end
    issue(4'b0011, ok);
    b = exp_beats.pop_front();
    n_checks++;
    if (!ok || o_gnt !== b.gnt || o_id_down !== b.id || o_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL to_next_grant: got gnt=%b id=%h to=%b required %b %h 0", o_gnt, o_id_down,
               o_timeout, b.gnt, b.id);
    end
    i_req = '0;
  endtask

  task automatic test_collision();
    bit    ok;
    beat_t b;
    cpl_t  c;
    do_reset();
    tok[2] = 32'h2222_0002;
    issue(4'b0100, ok);
    b = exp_beats.pop_front();
    n_checks++;
    if (!ok || o_gnt !== b.gnt || o_id_down !== b.id) begin
      n_fail++;
      $display("FAIL col_send: got gnt=%b id=%h required %b %h", o_gnt, o_id_down, b.gnt, b.id);
    end
    i_req = '0;
    for (int w = 0; w < 16; w++) step();
    i_wen_up = 1'b1;
    i_id_up = b.id;
    i_token_up = 32'hCAFE_0002;
    c.done = b.gnt;
    c.rsp = 32'hCAFE_0002;
    c.lat = mcnt - send_mcnt + 32'd1;
    exp_cpl.push_back(c);
    step();
    i_wen_up = 1'b0;
    c = exp_cpl.pop_front();
    n_checks++;
    if (o_done !== c.done || o_timeout !== 1'b0 || o_lat !== c.lat) begin
      n_fail++;
      $display("FAIL col_done_only: got done=%b to=%b lat=%0d required %b 0 %0d", o_done,
               o_timeout, o_lat, c.done, c.lat);
    end
    step();
    n_checks++;
    if (o_timeout !== 1'b0 || o_done !== 4'b0) begin
      n_fail++;
      $display("FAIL col_after: got to=%b done=%b required 0 0000", o_timeout, o_done);
    end
  endtask

  task automatic test_stray();
    bit    ok;
    beat_t b;
    cpl_t  c;
    int    remaining;
    int    n;
    do_reset();
    tok[0] = 32'h5555_0000;
    i_wen_up = 1'b1;
    i_id_up = 32'hFFFF_FFFF;
    step();
    i_wen_up = 1'b0;
    m_stray = 1;
    n_checks++;
    if (o_stray_cnt !== 8'(m_stray)) begin
      n_fail++;
      $display("FAIL stray_idle: got %0d required %0d", o_stray_cnt, m_stray);
    end
    remaining = 300;
    for (int txn = 0; txn < 30 && remaining > 0; txn++) begin
      issue(4'b0001, ok);
      b = exp_beats.pop_front();
      n_checks++;
      if (!ok || o_id_down !== b.id) begin
        n_fail++;
        $display("FAIL stray_send%0d: got id=%h required %h", txn, o_id_down, b.id);
      end
      i_req = '0;
      if (txn == 0) begin
        // Ack with the right id but during SEND: must not complete the transaction.
        i_wen_up = 1'b1;
        i_id_up = b.id;
        step();
        i_wen_up = 1'b0;
        if (m_stray < 255) m_stray++;
        n_checks++;
        if (o_stray_cnt !== 8'(m_stray) || o_busy !== 1'b1 || o_done !== 4'b0) begin
          n_fail++;
          $display("FAIL stray_send_ack: got cnt=%0d busy=%b done=%b required %0d 1 0000",
                   o_stray_cnt, o_busy, o_done, m_stray);
        end
      end else begin
        step();
      end
      n = (remaining < 14) ? remaining : 14;
      for (int i = 0; i < n; i++) begin
        i_wen_up = 1'b1;
        i_id_up = b.id ^ 32'h0000_0100;
        step();
        if (m_stray < 255) m_stray++;
        remaining--;
      end
      i_wen_up = 1'b1;
      i_id_up = b.id;
      i_token_up = 32'h0000_5000 + txn;
      c.done = 4'b0001;
      c.rsp = 32'h0000_5000 + txn;
      c.lat = mcnt - send_mcnt + 32'd1;
      exp_cpl.push_back(c);
      step();
      i_wen_up = 1'b0;
      c = exp_cpl.pop_front();
      n_checks++;
      if (o_done !== c.done || o_rsp_token !== c.rsp || o_stray_cnt !== 8'(m_stray)) begin
        n_fail++;
        $display("FAIL stray_txn%0d: got %b %h %0d required %b %h %0d", txn, o_done,
                 o_rsp_token, o_stray_cnt, c.done, c.rsp, m_stray);
      end
    end
    n_checks++;
    if (o_stray_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL stray_saturate: got %0d required 255", o_stray_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit    ok;
    bit    spurious;
    beat_t b;
    beat_t b2;
    do_reset();
    tok[0] = 32'h9000_0000;
    tok[1] = 32'h9000_0001;
    tok[3] = 32'h9000_0003;
    issue(4'b0010, ok);
    b = exp_beats.pop_front();
    n_checks++;
    if (!ok || o_gnt !== b.gnt) begin
      n_fail++;
      $display("FAIL rmid_send: got gnt=%b required %b", o_gnt, b.gnt);
    end
    i_req = '0;
    step();
    step();
    step();
    i_rstn = 1'b0;
    step();
    i_rstn = 1'b1;
    m_ptr = 0;
    m_seq = '0;
    n_checks++;
    if (o_busy !== 1'b0 || {o_gnt, o_token_down, o_id_down, o_clk_cnt_down} !== 100'b0) begin
      n_fail++;
      $display("FAIL rmid_cleared: got busy=%b tok=%h id=%h required 0 0 0", o_busy,
               o_token_down, o_id_down);
    end
    spurious = 1'b0;
    for (int w = 0; w < 20; w++) begin
      step();
      if (o_done !== 4'b0 || o_timeout !== 1'b0) spurious = 1'b1;
    end
    n_checks++;
    if (spurious) begin
      n_fail++;
      $display("FAIL rmid_no_cpl: got done/timeout after reset required none");
    end
    i_wen_up = 1'b1;
    i_id_up = b.id;
    step();
    i_wen_up = 1'b0;
    n_checks++;
    if (o_stray_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL rmid_late_ack: got %0d required 1", o_stray_cnt);
    end
    issue(4'b1001, ok);
    b2 = exp_beats.pop_front();
    n_checks++;
    if (!ok || o_gnt !== b2.gnt || o_id_down !== b2.id) begin
      n_fail++;
      $display("FAIL rmid_regrant: got gnt=%b id=%h required %b %h", o_gnt, o_id_down, b2.gnt,
               b2.id);
    end
    n_checks++;
    if (o_id_down !== {LINK_ID, 16'h0000, 8'h00}) begin
      n_fail++;
      $display("FAIL rmid_seq0: got %h required %h", o_id_down, {LINK_ID, 16'h0000, 8'h00});
    end
    i_req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_collision();
    test_stray();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
